// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers plus a sliding window,
// two register stages (gradients, then mode result), one pixel per clock.
module sobel_stream #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [PIX_W-1:0] In_Pixel,
  input  logic             In_SOF,
  input  logic [1:0]       Mode,
  input  logic [PIX_W+2:0] Threshold,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [PIX_W-1:0] Out_Pixel,
  output logic             Out_SOF,
  output logic             Out_EOL
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int GW = PIX_W + 3;
  localparam logic [GW-1:0] PMAX = GW'((1 << PIX_W) - 1);

  // Handshake: a port transfers on Valid && Ready. The whole pipeline moves
  // whenever In_Ready is high (output empty or being taken), input or not.
  logic adv, acc;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  logic [PIX_W-1:0] lb1_q [IMG_WIDTH];
  logic [PIX_W-1:0] lb2_q [IMG_WIDTH];
  logic [PIX_W-1:0] left_q [3];
  logic [PIX_W-1:0] ctr_q [3];
  logic [PIX_W-1:0] lb_top, lb_mid;

  logic                 win_ok, win_sof, win_eol;
  logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
  logic                 s1_valid_q, s1_sof_q, s1_eol_q;

  logic [GW-1:0]    abs_gx, abs_gy, mag, sel;
  logic [PIX_W-1:0] res_d;
  logic             out_valid_q, out_sof_q, out_eol_q;
  logic [PIX_W-1:0] out_pixel_q;

  assign In_Ready = Reset_n && (Out_Ready || !out_valid_q);
  assign adv      = In_Ready;
  assign acc      = adv && In_Valid;

  // In_SOF re-anchors the incoming pixel at (0,0) regardless of the counters.
  assign cur_col = In_SOF ? '0 : col_q;
  assign cur_row = In_SOF ? '0 : row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (acc) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign lb_top = lb2_q[cur_col];
  assign lb_mid = lb1_q[cur_col];

  // Line buffers and window columns need no reset: a centre is only emitted
  // once two rows and two columns of the current frame have refilled them.
  always_ff @(posedge Clk) begin
    if (acc) begin
      lb1_q[cur_col] <= In_Pixel;
      lb2_q[cur_col] <= lb_mid;
      for (int r = 0; r < 3; r++) left_q[r] <= ctr_q[r];
      ctr_q[0] <= lb_top;
      ctr_q[1] <= lb_mid;
      ctr_q[2] <= In_Pixel;
    end
  end

  function automatic logic [GW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  // Window columns: left_q = x-2, ctr_q = x-1, incoming = x; centre is (x-1,y-1).
  assign gx_d = $signed(wsum(lb_top, lb_mid, In_Pixel) -
                        wsum(left_q[0], left_q[1], left_q[2]));
  assign gy_d = $signed(wsum(left_q[2], ctr_q[2], In_Pixel) -
                        wsum(left_q[0], ctr_q[0], lb_top));

  assign win_ok  = acc && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
  assign win_sof = (cur_col == CW'(2)) && (cur_row == RW'(2));
  assign win_eol = (cur_col == CW'(IMG_WIDTH - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_eol_q   <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
    end else if (adv) begin
      s1_valid_q <= win_ok;
      s1_sof_q   <= win_sof;
      s1_eol_q   <= win_eol;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
    end
  end

  always_comb begin
    abs_gx = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
    abs_gy = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag    = abs_gx + abs_gy;
    case (Mode)
      2'b01:   sel = abs_gx;
      2'b10:   sel = abs_gy;
      default: sel = mag;
    endcase
    if (Mode == 2'b11) res_d = (mag >= Threshold) ? '1 : '0;
    else if (sel > PMAX) res_d = '1;
    else res_d = sel[PIX_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_pixel_q <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      out_sof_q   <= s1_valid_q && s1_sof_q;
      out_eol_q   <= s1_valid_q && s1_eol_q;
      out_pixel_q <= res_d;
    end
  end

  assign Out_Valid = out_valid_q;
  assign Out_SOF   = out_sof_q;
  assign Out_EOL   = out_eol_q;
  assign Out_Pixel = out_pixel_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 frame: constant, step edges,
// threshold boundary, random frame under back-pressure, mid-frame SOF and reset.
module tb_sobel_stream;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int P    = 8;
  localparam int NPIX = W * H;
  localparam int NOUT = (W - 2) * (H - 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, in_sof;
  logic         out_valid, out_ready, out_sof, out_eol;
  logic [P-1:0] in_pixel, out_pixel;
  logic [1:0]   mode;
  logic [P+2:0] thr;

  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(P)) dut (
    .Clk(clk), .Reset_n(rst_n),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_Pixel(in_pixel), .In_SOF(in_sof),
    .Mode(mode), .Threshold(thr),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_Pixel(out_pixel),
    .Out_SOF(out_sof), .Out_EOL(out_eol)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [P+1:0] exp_q[$];
  logic [P+1:0] got_q[$];
  logic [P+1:0] run1_q[$];
  int           got_cyc[$];
  logic [P-1:0] frame [NPIX];
  int           acc_cyc [NPIX];
  bit           rand_ready = 1'b0;
  bit           chk_hs     = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // ---------------- downstream ready ----------------
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor ----------------
  logic [P+2:0] held;
  bit           prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_q.push_back({out_sof, out_eol, out_pixel});
        got_cyc.push_back(cyc);
      end
      if (chk_hs) begin
        check("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (prev_stall) check("stall_hold", {out_valid, out_sof, out_eol, out_pixel}, held);
      end
      prev_stall = out_valid && !out_ready;
      held       = {out_valid, out_sof, out_eol, out_pixel};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input logic [P-1:0] pix, input logic sof, input int idx);
    int waited = 0;
    bit done   = 1'b0;
    in_valid = 1'b1;
    in_pixel = pix;
    in_sof   = sof;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        acc_cyc[idx] = cyc;
      end
      @(posedge clk); #1;
      waited++;
      if (!done && waited > 300) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int npix, input bit sof_first);
    for (int i = 0; i < npix; i++) send_pixel(frame[i], sof_first && (i == 0), i);
  endtask

  task automatic wait_outputs(input int n);
    int t = 0;
    while (got_q.size() < n && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (8) begin @(posedge clk); #1; end
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_exp(input int x, input int y, input logic [P-1:0] v);
    exp_q.push_back({(x == 1 && y == 1), (x == W - 2), v});
  endtask

  task automatic score(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_out%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  // Straight 2-D Sobel on the frame array, used for the random frames.
  function automatic logic [P-1:0] ref_px(input int x, input int y, input logic [1:0] md, input int th);
    int gx, gy, ax, ay, mag, sel;
    gx = (int'(frame[(y-1)*W+x+1]) + 2*int'(frame[y*W+x+1]) + int'(frame[(y+1)*W+x+1]))
       - (int'(frame[(y-1)*W+x-1]) + 2*int'(frame[y*W+x-1]) + int'(frame[(y+1)*W+x-1]));
    gy = (int'(frame[(y+1)*W+x-1]) + 2*int'(frame[(y+1)*W+x]) + int'(frame[(y+1)*W+x+1]))
       - (int'(frame[(y-1)*W+x-1]) + 2*int'(frame[(y-1)*W+x]) + int'(frame[(y-1)*W+x+1]));
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    if (md == 2'b11) return (mag >= th) ? 8'hFF : 8'h00;
    sel = (md == 2'b01) ? ax : (md == 2'b10) ? ay : mag;
    return (sel > 255) ? 8'hFF : 8'(sel);
  endfunction

  task automatic exp_ref_frame(input logic [1:0] md, input int th);
    for (int y = 1; y <= H - 2; y++)
      for (int x = 1; x <= W - 2; x++) push_exp(x, y, ref_px(x, y, md, th));
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    mode     = 2'b00;
    thr      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b0);
    check("rst_out_pixel", out_pixel, 8'd0);
    check("rst_out_flags", {out_sof, out_eol}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: constant frame
    for (int i = 0; i < NPIX; i++) frame[i] = 8'd77;
    for (int y = 1; y <= H - 2; y++) for (int x = 1; x <= W - 2; x++) push_exp(x, y, 8'd0);
    send_frame(NPIX, 1'b1);
    wait_outputs(NOUT);
    if (got_cyc.size() > 0) check("latency", got_cyc[0] - acc_cyc[2*W+2], 32'd2);
    else check("latency_no_output", 32'd0, 32'd1);
    score("const");

    // 2: vertical step edge
    for (int i = 0; i < NPIX; i++) frame[i] = ((i % W) < 4) ? 8'd0 : 8'd255;
    mode = 2'b00;
    for (int y = 1; y <= H - 2; y++)
      for (int x = 1; x <= W - 2; x++) push_exp(x, y, (x == 3 || x == 4) ? 8'd255 : 8'd0);
    send_frame(NPIX, 1'b1);
    wait_outputs(NOUT);
    score("vstep_m00");
    mode = 2'b10;
    for (int y = 1; y <= H - 2; y++) for (int x = 1; x <= W - 2; x++) push_exp(x, y, 8'd0);
    send_frame(NPIX, 1'b1);
    wait_outputs(NOUT);
    score("vstep_m10");

    // 3: horizontal step edge, threshold mode at and around mag=400
    for (int i = 0; i < NPIX; i++) frame[i] = ((i / W) < 3) ? 8'd0 : 8'd100;
    mode = 2'b11;
    for (int t = 0; t < 3; t++) begin
      thr = (t == 0) ? 11'd300 : (t == 1) ? 11'd400 : 11'd401;
      for (int y = 1; y <= H - 2; y++)
        for (int x = 1; x <= W - 2; x++)
          push_exp(x, y, ((y == 2 || y == 3) && t < 2) ? 8'd255 : 8'd0);
      send_frame(NPIX, 1'b1);
      wait_outputs(NOUT);
      score($sformatf("hstep_thr%0d", thr));
    end

    // 4: random frame, free-running then with back-pressure
    mode = 2'b00;
    fill_random();
    exp_ref_frame(2'b00, 0);
    send_frame(NPIX, 1'b1);
    wait_outputs(NOUT);
    run1_q = got_q;
    score("rand_free");
    rand_ready = 1'b1;
    chk_hs     = 1'b1;
    send_frame(NPIX, 1'b1);
    wait_outputs(NOUT);
    exp_q = run1_q;
    score("rand_stall");
    chk_hs     = 1'b0;
    rand_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // 5: SOF arrives at (5,3); earlier rows must not leak into the new frame
    for (int i = 0; i < NPIX; i++) frame[i] = (((i % W) + (i / W)) % 2 == 0) ? 8'd255 : 8'd0;
    for (int x = 1; x <= W - 2; x++) push_exp(x, 1, ref_px(x, 1, 2'b00, 0));
    for (int x = 1; x <= 3; x++) push_exp(x, 2, ref_px(x, 2, 2'b00, 0));
    send_frame(3*W + 5, 1'b1);
    fill_random();
    exp_ref_frame(2'b00, 0);
    send_frame(NPIX, 1'b1);
    wait_outputs(9 + NOUT);
    score("midsof");

    // 6: one-cycle reset in the middle of a frame
    mode = 2'b01;
    fill_random();
    send_frame(30, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_pixel", out_pixel, 8'd0);
    check("midrst_out_flags", {out_sof, out_eol}, 2'b00);
    check("midrst_in_ready2", in_ready, 1'b0);
    rst_n = 1'b1;
    got_q.delete();
    got_cyc.delete();
    fill_random();
    exp_ref_frame(2'b01, 0);
    send_frame(NPIX, 1'b0);
    wait_outputs(NOUT);
    score("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
